// File: rtl/pat_pkg.sv
// rtl/pat_pkg.sv - shared constants, state enum and length clamp for the pattern store and sequencer
package pat_pkg;

    localparam int BUFSIZE = 27;
    localparam int NOBUFS  = 8;
    localparam int SELW    = $clog2(NOBUFS);
    localparam int ADDRW   = 5;
    localparam int DIVW    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        PRESENT,
        GAP,
        DONE
    } seq_state_t;

    function automatic logic [ADDRW-1:0] clamp_len(input logic [ADDRW-1:0] l);
        return (l > ADDRW'(BUFSIZE)) ? ADDRW'(BUFSIZE) : l;
    endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// rtl/pattern_sequencer_if.sv - store read port plus pattern byte stream between sequencer and neighbours
interface pattern_sequencer_if;
    import pat_pkg::*;

    logic             rd_en;
    logic [SELW-1:0]  rd_buf;
    logic [ADDRW-1:0] rd_addr;
    logic [7:0]       rd_data;
    logic [7:0]       pat_data;
    logic             pat_valid;
    logic             pat_ready;

    modport master (
        output rd_en, rd_buf, rd_addr, pat_data, pat_valid,
        input  rd_data, pat_ready
    );

    modport slave (
        input  rd_en, rd_buf, rd_addr, pat_data, pat_valid,
        output rd_data, pat_ready
    );

endinterface

// File: rtl/pattern_gap_timer.sv
// rtl/pattern_gap_timer.sv - loadable down-counter timing the idle gap after each accepted byte
module pattern_gap_timer
    import pat_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DIVW-1:0] load_val,
    input  logic            en,
    output logic            expired
);

    logic [DIVW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - DIVW'(1);
        end
    end

    // Expires in the last counted cycle so the gap lasts exactly load_val cycles.
    assign expired = (cnt_q <= DIVW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - plays one pattern buffer onto a valid/ready byte stream; PATSEQ_LOOP_EN adds repeat passes
module pattern_sequencer
    import pat_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [SELW-1:0]  buf_sel,
    input  logic [ADDRW-1:0] len,
    input  logic [DIVW-1:0]  div,
`ifdef PATSEQ_LOOP_EN
    input  logic [7:0]       loop_cnt,
`endif
    output logic             busy,
    output logic             done,
    pattern_sequencer_if.master bus
);

    seq_state_t       state_q, state_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [ADDRW-1:0] len_q, len_d;
    logic [DIVW-1:0]  div_q, div_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             tmr_load, tmr_en, tmr_expired;
    logic             last_pass;

`ifdef PATSEQ_LOOP_EN
    logic [7:0] pass_q, pass_d;
    assign last_pass = (pass_q == 8'd0);
`else
    assign last_pass = 1'b1;
`endif

    pattern_gap_timer u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (div_q),
        .en       (tmr_en),
        .expired  (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        len_d    = len_q;
        div_d    = div_q;
        addr_d   = addr_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
`ifdef PATSEQ_LOOP_EN
        pass_d   = pass_q;
`endif
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sel_d  = buf_sel;
                        len_d  = clamp_len(len);
                        div_d  = div;
                        addr_d = '0;
`ifdef PATSEQ_LOOP_EN
                        pass_d = loop_cnt;
`endif
                        // An empty request spends one cycle in GAP so done lands where a fetch would have.
                        state_d = (len == '0) ? GAP : FETCH;
                    end
                end
                FETCH: state_d = CAPT;
                CAPT: begin
                    data_d  = bus.rd_data;
                    state_d = PRESENT;
                end
                PRESENT: begin
                    if (bus.pat_ready) begin
                        if (addr_q == len_q - ADDRW'(1)) begin
                            addr_d = '0;
                        end else begin
                            addr_d = addr_q + ADDRW'(1);
                        end
                        if ((addr_q == len_q - ADDRW'(1)) && last_pass) begin
                            state_d = DONE;
                        end else begin
`ifdef PATSEQ_LOOP_EN
                            if (addr_q == len_q - ADDRW'(1)) begin
                                pass_d = pass_q - 8'd1;
                            end
`endif
                            tmr_load = 1'b1;
                            state_d  = (div_q == '0) ? FETCH : GAP;
                        end
                    end
                end
                GAP: begin
                    tmr_en = 1'b1;
                    if (len_q == '0) begin
                        state_d = DONE;
                    end else if (tmr_expired) begin
                        state_d = FETCH;
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.rd_en     = (state_q == FETCH);
    assign bus.rd_buf    = sel_q;
    assign bus.rd_addr   = addr_q;
    assign bus.pat_data  = data_q;
    assign bus.pat_valid = (state_q == PRESENT);
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            len_q   <= '0;
            div_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef PATSEQ_LOOP_EN
            pass_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            div_q   <= div_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef PATSEQ_LOOP_EN
            pass_q  <= pass_d;
`endif
        end
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - scoreboard bench for pattern_sequencer; define PATSEQ_LOOP_EN to cover looping
module tb_pattern_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] buf_sel = '0;
    logic [4:0] len = '0;
    logic [7:0] div = '0;
`ifdef PATSEQ_LOOP_EN
    logic [7:0] loop_cnt = '0;
`endif
    logic       busy;
    logic       done;

    pattern_sequencer_if bus();

    pattern_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .buf_sel  (buf_sel),
        .len      (len),
        .div      (div),
`ifdef PATSEQ_LOOP_EN
        .loop_cnt (loop_cnt),
`endif
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:7][0:31];
    logic [7:0] exp_q [$];
    logic [7:0] hold_data;
    bit         hold_act;
    int total = 0, bad = 0;
    int cyc = 0, acc_cnt = 0, acc_in_run = 0, last_acc_cyc = 0;
    int done_cnt = 0, rd_cnt = 0, max_addr = 0, exp_period = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    initial begin
        for (int b = 0; b < 8; b++)
            for (int a = 0; a < 32; a++)
                mem[b][a] = (a < 27) ? 8'((b * 32 + a) ^ 8'h5a) : 8'hee;
        for (int a = 0; a < 11; a++) mem[3][a] = 8'h10 + 8'(a);
        for (int a = 0; a < 3; a++)  mem[7][a] = 8'ha0 + 8'(a);
    end

    // Synchronous-read store model
    initial begin
        bus.rd_data = '0;
        forever begin
            @(posedge clk);
            if (bus.rd_en) bus.rd_data <= mem[bus.rd_buf][bus.rd_addr];
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: a valid&&ready seen here is accepted at the following rising edge
    initial forever begin
        @(negedge clk);
        if (rst) begin
            hold_act = 0;
        end else begin
            if (bus.rd_en) begin
                rd_cnt++;
                if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
            end
            if (bus.pat_valid && bus.pat_ready) begin
                chk_eq("sb_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk_eq("byte", bus.pat_data, exp_q.pop_front());
                if (exp_period != 0 && acc_in_run > 0) chk_eq("period", cyc - last_acc_cyc, exp_period);
                last_acc_cyc = cyc;
                acc_in_run++;
                acc_cnt++;
                hold_act = 0;
            end else if (bus.pat_valid) begin
                if (hold_act) chk_eq("hold_data", bus.pat_data, hold_data);
                else begin
                    hold_act  = 1;
                    hold_data = bus.pat_data;
                end
            end else begin
                hold_act = 0;
            end
            if (done) begin
                done_cnt++;
                if (acc_in_run > 0) chk_eq("done_lat", cyc - last_acc_cyc, 1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulses start for one edge and loads the scoreboard; returns 1 ns after that edge
    task automatic go(input int sel, input int l, input int d, input int loops, input int per);
        int eff;
        eff = (l > 27) ? 27 : l;
        for (int p = 0; p <= loops; p++)
            for (int i = 0; i < eff; i++) exp_q.push_back(mem[sel][i]);
        buf_sel    = 3'(sel);
        len        = 5'(l);
        div        = 8'(d);
        exp_period = per;
        acc_in_run = 0;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0, n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step(1);
            n++;
        end
        chk_eq(tag, done_cnt - d0, 1);
        step(1);
        chk_eq({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int n, a0, d0, r0;
        bus.pat_ready = 1'b0;
        step(3);
        chk_eq("rst_valid", bus.pat_valid, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_rd_en", bus.rd_en, 0);
        rst = 1'b0;
        step(2);

        // Single pass, back-to-back accepts, start-to-read latency
        bus.pat_ready = 1'b1;
        go(3, 11, 0, 0, 3);
        chk_eq("t1_rd_en", bus.rd_en, 1);
        chk_eq("t1_rd_buf", bus.rd_buf, 3);
        chk_eq("t1_rd_addr", bus.rd_addr, 0);
        chk_eq("t1_busy", busy, 1);
        step(1);
        chk_eq("t1_rd_en_once", bus.rd_en, 0);
        step(1);
        chk_eq("t1_first_valid", bus.pat_valid, 1);
        chk_eq("t1_first_data", bus.pat_data, 8'h10);
        wait_done("t1_done", 60);
        chk_eq("t1_idle", busy, 0);

        // Empty request and over-length clamp
        r0 = rd_cnt;
        d0 = done_cnt;
        go(2, 0, 0, 0, 0);
        chk_eq("t2_busy", busy, 1);
        chk_eq("t2_no_done_yet", done, 0);
        step(1);
        chk_eq("t2_done", done, 1);
        step(1);
        chk_eq("t2_done_once", done_cnt - d0, 1);
        chk_eq("t2_idle", busy, 0);
        chk_eq("t2_no_reads", rd_cnt - r0, 0);
        r0 = rd_cnt;
        max_addr = 0;
        go(5, 31, 0, 0, 3);
        wait_done("t2_clamp_done", 120);
        chk_eq("t2_clamp_reads", rd_cnt - r0, 27);
        chk_eq("t2_max_addr", max_addr, 26);

        // Inter-byte gap, then consumer back-pressure
        go(2, 4, 5, 0, 8);
        wait_done("t3_gap_done", 60);
        bus.pat_ready = 1'b0;
        go(1, 3, 0, 0, 0);
        n = 0;
        while (!bus.pat_valid && n < 10) begin
            step(1);
            n++;
        end
        chk_eq("t3_valid_seen", bus.pat_valid, 1);
        step(4);
        chk_eq("t3_stall_valid", bus.pat_valid, 1);
        chk_eq("t3_stall_data", bus.pat_data, mem[1][0]);
        bus.pat_ready = 1'b1;
        wait_done("t3_stall_done", 40);

        // Abort while the fourth byte is being fetched
        a0 = acc_cnt;
        d0 = done_cnt;
        go(4, 10, 0, 0, 3);
        n = 0;
        while (acc_cnt - a0 < 3 && n < 40) begin
            step(1);
            n++;
        end
        chk_eq("t4_three_acc", acc_cnt - a0, 3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk_eq("t4_valid_off", bus.pat_valid, 0);
        chk_eq("t4_busy_off", busy, 0);
        step(8);
        chk_eq("t4_no_more_acc", acc_cnt - a0, 3);
        chk_eq("t4_no_done", done_cnt - d0, 0);
        chk_eq("t4_left_in_sb", exp_q.size(), 7);
        exp_q.delete();
        go(4, 2, 0, 0, 3);
        wait_done("t4_restart_done", 30);

        // Ignored start and changed inputs mid-playback, then reset mid-playback
        go(6, 5, 2, 0, 5);
        step(4);
        buf_sel = 3'd7;
        len     = 5'd9;
        div     = 8'd0;
        start   = 1'b1;
        step(1);
        start   = 1'b0;
        wait_done("t5_intact_done", 60);
        go(5, 8, 0, 0, 3);
        step(4);
        rst = 1'b1;
        step(1);
        chk_eq("t5_rst_rd_en", bus.rd_en, 0);
        chk_eq("t5_rst_rd_buf", bus.rd_buf, 0);
        chk_eq("t5_rst_rd_addr", bus.rd_addr, 0);
        chk_eq("t5_rst_data", bus.pat_data, 0);
        chk_eq("t5_rst_valid", bus.pat_valid, 0);
        chk_eq("t5_rst_busy", busy, 0);
        chk_eq("t5_rst_done", done, 0);
        exp_q.delete();
        rst = 1'b0;
        step(2);

`ifdef PATSEQ_LOOP_EN
        d0 = done_cnt;
        a0 = acc_cnt;
        loop_cnt = 8'd2;
        go(7, 3, 0, 2, 3);
        loop_cnt = 8'd0;
        wait_done("t6_loop_done", 60);
        chk_eq("t6_loop_bytes", acc_cnt - a0, 9);
        step(3);
        chk_eq("t6_single_done", done_cnt - d0, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
